// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-system port between the instruction cache
// (read-only) and the data cache (read or write). A three-state FSM owns the
// port, breaks ties round-robin, chains back-to-back grants without idle
// cycles and abandons a grant that waits too long for the memory system.
`timescale 1ns/1ps

module mem_arbiter #(
   parameter int TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        rst,
   // instruction-side request
   input  logic        ic_rd,
   input  logic [15:0] ic_addr,
   // data-side request
   input  logic        dc_rd,
   input  logic        dc_wr,
   input  logic [15:0] dc_addr,
   input  logic [15:0] dc_wdata,
   // shared memory-system port
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_done,
   input  logic [15:0] mem_rdata,
   // instruction-side responses
   output logic        ic_done,
   output logic        ic_stall,
   output logic [15:0] ic_rdata,
   // data-side responses
   output logic        dc_done,
   output logic        dc_stall,
   output logic [15:0] dc_rdata,
   // illegal request or timeout
   output logic        err
);

   // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   typedef enum logic {
      SRV_IC = 1'b0,
      SRV_DC = 1'b1
   } srv_t;

   state_t          r_state;
   state_t          w_nextState;
   srv_t            r_lastSrv;
   logic [CW-1:0]   r_waitCnt;
   logic            r_timeoutFlag;

   logic            w_icValid;
   logic            w_dcValid;
   logic            w_icIllegal;
   logic            w_dcIllegal;
   logic            w_timeoutHit;
   logic            w_grantActive;
   logic            w_icDone;
   logic            w_dcDone;

   // Classify the incoming requests: a misaligned address or a data-side
   // request that is both read and write never enters arbitration, it only
   // raises err.
   always_comb begin
      w_icValid   = ic_rd & ~ic_addr[0];
      w_dcValid   = (dc_rd ^ dc_wr) & ~dc_addr[0];
      w_icIllegal = ic_rd & ic_addr[0];
      w_dcIllegal = ((dc_rd | dc_wr) & dc_addr[0]) | (dc_rd & dc_wr);
   end

   // A grant times out in the cycle the counter sits at its last value and
   // the memory system still has not answered.
   always_comb begin
      w_grantActive = (r_state != IDLE);
      w_timeoutHit  = w_grantActive & (r_waitCnt == LAST_WAIT) & ~mem_done;
   end

   // Next-state logic. On completion the other requester has priority so a
   // busy pair alternates; the finishing requester is re-granted only when
   // the other side is not asking. Request levels are ignored mid-grant so a
   // requester that drops early cannot cut a grant short.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_icValid && w_dcValid) begin
               w_nextState = (r_lastSrv == SRV_IC) ? GNT_D : GNT_I;
            end else if (w_icValid) begin
               w_nextState = GNT_I;
            end else if (w_dcValid) begin
               w_nextState = GNT_D;
            end
         end
         GNT_I: begin
            if (mem_done) begin
               if (w_dcValid) begin
                  w_nextState = GNT_D;
               end else if (w_icValid) begin
                  w_nextState = GNT_I;
               end else begin
                  w_nextState = IDLE;
               end
            end else if (w_timeoutHit) begin
               w_nextState = IDLE;
            end
         end
         GNT_D: begin
            if (mem_done) begin
               if (w_icValid) begin
                  w_nextState = GNT_I;
               end else if (w_dcValid) begin
                  w_nextState = GNT_D;
               end else begin
                  w_nextState = IDLE;
               end
            end else if (w_timeoutHit) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State register. The data cache wins the first tie after reset because
   // the pointer starts out claiming the instruction side was served last.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Round-robin pointer, moved only when a grant completes normally so a
   // timed-out requester keeps its place in line.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lastSrv <= SRV_IC;
      end else if (mem_done && (r_state == GNT_I)) begin
         r_lastSrv <= SRV_IC;
      end else if (mem_done && (r_state == GNT_D)) begin
         r_lastSrv <= SRV_DC;
      end
   end

   // Wait counter. It rests at zero while idle and is cleared on every
   // completion or timeout, so each grant (including a re-grant) starts
   // counting from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_waitCnt <= '0;
      end else if (!w_grantActive || mem_done || w_timeoutHit) begin
         r_waitCnt <= '0;
      end else begin
         r_waitCnt <= r_waitCnt + 1'b1;
      end
   end

   // Sticky timeout flag; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timeoutFlag <= 1'b0;
      end else if (w_timeoutHit) begin
         r_timeoutFlag <= 1'b1;
      end
   end

   // Completion pulses. They are suppressed while reset is asserted so a
   // transaction aborted by reset never reports done.
   always_comb begin
      w_icDone = ~rst & (r_state == GNT_I) & mem_done;
      w_dcDone = ~rst & (r_state == GNT_D) & mem_done;
   end

   // Memory port drive. The granted requester's command is forwarded every
   // cycle of the grant, including the completion cycle; idle and reset
   // leave the port fully quiet.
   always_comb begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
      if (!rst) begin
         case (r_state)
            GNT_I: begin
               mem_rd   = 1'b1;
               mem_addr = ic_addr;
            end
            GNT_D: begin
               mem_rd    = dc_rd;
               mem_wr    = dc_wr;
               mem_addr  = dc_addr;
               mem_wdata = dc_wdata;
            end
            default: begin
               mem_rd = 1'b0;
            end
         endcase
      end
   end

   // Requester responses: done pulse, read data only alongside done, and a
   // stall for as long as a request is pending without completion.
   always_comb begin
      ic_done  = w_icDone;
      dc_done  = w_dcDone;
      ic_rdata = w_icDone ? mem_rdata : 16'h0000;
      dc_rdata = w_dcDone ? mem_rdata : 16'h0000;
      ic_stall = ic_rd & ~w_icDone;
      dc_stall = (dc_rd | dc_wr) & ~w_dcDone;
   end

   // Error output: sticky timeout plus same-cycle illegal-request detection,
   // held low while reset is asserted.
   always_comb begin
      err = ~rst & (r_timeoutFlag | w_icIllegal | w_dcIllegal);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Expected grants are queued
// as requests are raised and popped when the arbiter drives the memory port.
`timescale 1ns/1ps

module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        ic_rd;
   logic [15:0] ic_addr;
   logic        dc_rd;
   logic        dc_wr;
   logic [15:0] dc_addr;
   logic [15:0] dc_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_done;
   logic [15:0] mem_rdata;
   logic        ic_done;
   logic        ic_stall;
   logic [15:0] ic_rdata;
   logic        dc_done;
   logic        dc_stall;
   logic [15:0] dc_rdata;
   logic        err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          isDc;
      logic [15:0] addr;
      logic        rd;
      logic        wr;
      logic [15:0] wdata;
   } grant_t;

   grant_t expQ[$];

   mem_arbiter #(.TIMEOUT(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .ic_rd     (ic_rd),
      .ic_addr   (ic_addr),
      .dc_rd     (dc_rd),
      .dc_wr     (dc_wr),
      .dc_addr   (dc_addr),
      .dc_wdata  (dc_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_done  (mem_done),
      .mem_rdata (mem_rdata),
      .ic_done   (ic_done),
      .ic_stall  (ic_stall),
      .ic_rdata  (ic_rdata),
      .dc_done   (dc_done),
      .dc_stall  (dc_stall),
      .dc_rdata  (dc_rdata),
      .err       (err)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before end of sequence");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushIc(input logic [15:0] addr);
      grant_t g;
      g.isDc = 1'b0; g.addr = addr; g.rd = 1'b1; g.wr = 1'b0; g.wdata = 16'h0000;
      expQ.push_back(g);
   endtask

   task automatic pushDc(input logic [15:0] addr, input logic rd, input logic wr,
                         input logic [15:0] wdata);
      grant_t g;
      g.isDc = 1'b1; g.addr = addr; g.rd = rd; g.wr = wr; g.wdata = wdata;
      expQ.push_back(g);
   endtask

   task automatic applyStimulus(input logic icRd, input logic [15:0] icAddr,
                                input logic dcRd, input logic dcWr,
                                input logic [15:0] dcAddr, input logic [15:0] dcWdata);
      ic_rd    = icRd;
      ic_addr  = icAddr;
      dc_rd    = dcRd;
      dc_wr    = dcWr;
      dc_addr  = dcAddr;
      dc_wdata = dcWdata;
   endtask

   // Serve the grant at the head of the queue: entered just after the edge
   // that starts the grant, answers with mem_done after lat cycles and, in
   // the done cycle, withdraws the requests selected by dropMask
   // (bit0 = instruction side, bit1 = data side) before the next edge.
   task automatic serveGrant(input int lat, input logic [15:0] rdata,
                             input logic [1:0] dropMask);
      grant_t g;
      bit last;
      checkOutput("scoreboardDepth", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() == 0) return;
      g = expQ.pop_front();
      for (int k = 0; k < lat; k++) begin
         last      = (k == lat - 1);
         mem_done  = last;
         mem_rdata = last ? rdata : 16'hDEAD;
         #1;
         checkOutput(g.isDc ? "gntD.memRd"    : "gntI.memRd",    mem_rd,    g.rd);
         checkOutput(g.isDc ? "gntD.memWr"    : "gntI.memWr",    mem_wr,    g.wr);
         checkOutput(g.isDc ? "gntD.memAddr"  : "gntI.memAddr",  mem_addr,  g.addr);
         checkOutput(g.isDc ? "gntD.memWdata" : "gntI.memWdata", mem_wdata, g.wdata);
         if (g.isDc) begin
            checkOutput("gntD.dcDone",  dc_done,  last);
            checkOutput("gntD.dcRdata", dc_rdata, last ? rdata : 16'h0000);
            checkOutput("gntD.dcStall", dc_stall, !last);
            checkOutput("gntD.icDone",  ic_done,  1'b0);
         end else begin
            checkOutput("gntI.icDone",  ic_done,  last);
            checkOutput("gntI.icRdata", ic_rdata, last ? rdata : 16'h0000);
            checkOutput("gntI.icStall", ic_stall, !last);
            checkOutput("gntI.dcDone",  dc_done,  1'b0);
         end
         if (last) begin
            if (dropMask[0]) ic_rd = 1'b0;
            if (dropMask[1]) begin
               dc_rd = 1'b0;
               dc_wr = 1'b0;
            end
         end
         tick();
      end
      mem_done  = 1'b0;
      mem_rdata = 16'h0000;
   endtask

   // Directed sequence.
   initial begin
      rst       = 1'b1;
      mem_done  = 1'b0;
      mem_rdata = 16'h0000;
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      tick();
      tick();

      // Outputs quiet during reset, stalls still follow requests.
      applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0000);
      #1;
      checkOutput("rst.memRd",   mem_rd,   1'b0);
      checkOutput("rst.memAddr", mem_addr, 16'h0000);
      checkOutput("rst.err",     err,      1'b0);
      checkOutput("rst.icDone",  ic_done,  1'b0);
      checkOutput("rst.icStall", ic_stall, 1'b1);
      checkOutput("rst.dcStall", dc_stall, 1'b1);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      #1;
      checkOutput("postRst.err", err, 1'b0);

      // Simultaneous requests after reset: data side first, then instruction.
      applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, 16'h0000);
      #1;
      checkOutput("tie.idleMemRd", mem_rd,   1'b0);
      checkOutput("tie.idleErr",   err,      1'b0);
      checkOutput("tie.icStall",   ic_stall, 1'b1);
      pushDc(16'h0200, 1'b1, 1'b0, 16'h0000);
      pushIc(16'h0100);
      tick();
      serveGrant(2, 16'hA5A5, 2'b10);
      serveGrant(1, 16'h5A5A, 2'b01);
      #1;
      checkOutput("tie.endMemRd",   mem_rd,   1'b0);
      checkOutput("tie.endMemAddr", mem_addr, 16'h0000);

      // Single store with a three-cycle memory latency.
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'hBEEF);
      #1;
      checkOutput("wr.idleMemWr", mem_wr,   1'b0);
      checkOutput("wr.dcStall",   dc_stall, 1'b1);
      pushDc(16'h1234, 1'b0, 1'b1, 16'hBEEF);
      tick();
      serveGrant(3, 16'h1111, 2'b10);
      #1;
      checkOutput("wr.endMemWr",    mem_wr,    1'b0);
      checkOutput("wr.endMemWdata", mem_wdata, 16'h0000);
      checkOutput("wr.endDcDone",   dc_done,   1'b0);
      checkOutput("wr.endDcStall",  dc_stall,  1'b0);

      // Illegal requests: flagged the same cycle, never granted.
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0000);
      #1;
      checkOutput("ill.oddErr",   err,      1'b1);
      checkOutput("ill.oddMemRd", mem_rd,   1'b0);
      checkOutput("ill.dcStall",  dc_stall, 1'b1);
      tick();
      checkOutput("ill.noGrant",  mem_rd,   1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h0000);
      #1;
      checkOutput("ill.rdWrErr",  err,      1'b1);
      tick();
      checkOutput("ill.rdWrNoGntRd", mem_rd, 1'b0);
      checkOutput("ill.rdWrNoGntWr", mem_wr, 1'b0);
      applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000);
      #1;
      checkOutput("ill.icOddErr", err, 1'b1);
      tick();
      checkOutput("ill.icNoGrant", mem_rd, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      #1;
      checkOutput("ill.clearErr", err, 1'b0);

      // Both sides requesting continuously: data side was served last, so
      // the instruction side goes first and the grants alternate.
      applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000);
      pushIc(16'h0010);
      pushDc(16'h0020, 1'b1, 1'b0, 16'h0000);
      pushIc(16'h0010);
      pushDc(16'h0020, 1'b1, 1'b0, 16'h0000);
      tick();
      serveGrant(1, 16'h0001, 2'b00);
      serveGrant(1, 16'h0002, 2'b00);
      serveGrant(1, 16'h0003, 2'b00);
      serveGrant(1, 16'h0004, 2'b11);
      #1;
      checkOutput("alt.endMemRd", mem_rd, 1'b0);

      // Memory never answers: grant abandoned after 32 cycles, err sticky.
      applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000);
      #1;
      checkOutput("to.preErr", err, 1'b0);
      tick();
      for (int k = 0; k < 32; k++) begin
         #1;
         checkOutput("to.memRd",   mem_rd,   1'b1);
         checkOutput("to.memAddr", mem_addr, 16'h0040);
         checkOutput("to.errLow",  err,      1'b0);
         tick();
      end
      #1;
      checkOutput("to.idleMemRd", mem_rd,   1'b0);
      checkOutput("to.errSet",    err,      1'b1);
      checkOutput("to.icStall",   ic_stall, 1'b1);
      ic_rd = 1'b0;
      tick();
      tick();
      checkOutput("to.errSticky", err,    1'b1);
      checkOutput("to.stillIdle", mem_rd, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("to.errInRst", err, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("to.errCleared", err, 1'b0);

      // Reset in the middle of an instruction grant, coinciding with
      // mem_done: no done pulse, port released.
      applyStimulus(1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, 16'h0000);
      tick();
      #1;
      checkOutput("abort.memRd", mem_rd, 1'b1);
      tick();
      rst       = 1'b1;
      mem_done  = 1'b1;
      mem_rdata = 16'h7777;
      #1;
      checkOutput("abort.icDone",  ic_done,  1'b0);
      checkOutput("abort.icRdata", ic_rdata, 16'h0000);
      checkOutput("abort.memRd",   mem_rd,   1'b0);
      checkOutput("abort.err",     err,      1'b0);
      checkOutput("abort.icStall", ic_stall, 1'b1);
      tick();
      rst       = 1'b0;
      mem_done  = 1'b0;
      mem_rdata = 16'h0000;
      ic_rd     = 1'b0;
      #1;
      checkOutput("abort.idleMemRd", mem_rd,  1'b0);
      checkOutput("abort.idleDone",  ic_done, 1'b0);
      checkOutput("abort.idleErr",   err,     1'b0);

      // Reset restored the pointer: data side wins the next tie again.
      applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0300, 16'h0000);
      pushDc(16'h0300, 1'b1, 1'b0, 16'h0000);
      pushIc(16'h0100);
      tick();
      serveGrant(1, 16'hCAFE, 2'b10);
      serveGrant(2, 16'hF00D, 2'b01);
      #1;
      checkOutput("tie2.endMemRd", mem_rd, 1'b0);
      checkOutput("scoreboardDrained", expQ.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32: maximum number of cycles a grant may wait for mem_done before an error is raised.
REQ-002 SHALL have port clk, input, 1: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ic_rd in 1, instruction-side read request (level, held until ic_done); ic_addr in 16, instruction fetch address.
REQ-005 SHALL have dc_rd in 1 and dc_wr in 1, data-side requests (level, held until dc_done); dc_addr in 16; dc_wdata in 16, store data.
REQ-006 SHALL have mem_rd out 1, mem_wr out 1, mem_addr out 16, mem_wdata out 16: the shared memory-system port.
REQ-007 SHALL have mem_done in 1, memory-system completion; mem_rdata in 16, read data, valid when mem_done=1.
REQ-008 SHALL have ic_done out 1, ic_stall out 1, ic_rdata out 16; dc_done out 1, dc_stall out 1, dc_rdata out 16.
REQ-009 SHALL have err out 1: illegal request or timeout error.

Function
REQ-010 SHALL implement FSM states IDLE, GNT_I, GNT_D; GNT_I/GNT_D each own the memory port.
REQ-011 A request is valid when: IC: ic_rd & ~ic_addr[0]; DC: (dc_rd ^ dc_wr) & ~dc_addr[0]; an invalid request SHALL be excluded from arbitration.
REQ-012 In IDLE with a valid request in cycle N, the FSM SHALL enter the corresponding grant state at cycle N+1.
REQ-013 On simultaneous valid requests, grant SHALL go to the requester not served most recently (round-robin pointer last_srv, updated when each grant completes).
REQ-014 In GNT_I: mem_rd=1, mem_wr=0, mem_addr=ic_addr, mem_wdata=0; in GNT_D: mem_rd=dc_rd, mem_wr=dc_wr, mem_addr=dc_addr, mem_wdata=dc_wdata; in IDLE all mem_* SHALL be 0.
REQ-015 mem_rd/mem_wr SHALL be held asserted every cycle of the grant, including the mem_done cycle.
REQ-016 ic_done SHALL equal (state==GNT_I) & mem_done, combinationally; likewise dc_done for GNT_D; done is a one-cycle pulse per transaction.
REQ-017 ic_rdata/dc_rdata SHALL equal mem_rdata when the respective done is 1, else 0.
REQ-018 ic_stall SHALL equal ic_rd & ~ic_done; dc_stall SHALL equal (dc_rd|dc_wr) & ~dc_done.
REQ-019 On mem_done in a grant state: if the other requester is valid, go directly to its grant state next cycle; else if the same requester is still valid, re-grant it only when the other is absent; else go to IDLE.
REQ-020 A wait counter SHALL clear on grant entry and increment each grant cycle without mem_done; when it reaches TIMEOUT-1 without mem_done, the FSM SHALL go to IDLE and set a sticky timeout flag.
REQ-021 err SHALL equal sticky timeout flag | (ic_rd & ic_addr[0]) | ((dc_rd|dc_wr) & dc_addr[0]) | (dc_rd & dc_wr); illegal-request terms are combinational, same cycle.
REQ-022 Requests dropping mid-grant (protocol violation) SHALL NOT alter the grant; the grant ends only on mem_done or timeout.
REQ-023 Latency SHALL be one arbitration cycle from IDLE plus the memory-system latency; zero idle cycles between back-to-back grants.

Reset
REQ-024 On rst=1 at a clock edge: state=IDLE, last_srv=IC (DC wins first tie), wait counter=0, timeout flag=0.
REQ-025 During and after reset all outputs SHALL be 0 except stalls, which follow REQ-018; reset mid-grant SHALL abort the transaction with no done pulse.

Verification
REQ-026 Reset, then ic_rd=1, dc_rd=1 same cycle -> GNT_D next cycle, mem_addr=dc_addr; on mem_done dc_done=1, next cycle GNT_I with mem_addr=ic_addr.
REQ-027 Single dc_wr, dc_addr=0x1234, dc_wdata=0xBEEF, mem_done after 3 cycles -> mem_wr=1 for 3 cycles, dc_stall=1 until done cycle, dc_done one-cycle pulse, then IDLE.
REQ-028 dc_rd=1 with dc_addr=0x0003 -> err=1 that cycle, no grant, mem_rd stays 0; ic_rd and dc_rd both valid continuously -> grants alternate I/D/I/D.
REQ-029 Grant with mem_done never asserted, TIMEOUT=32 -> FSM to IDLE after 32 grant cycles, err=1 sticky until rst.
REQ-030 rst asserted during GNT_I -> next cycle IDLE, ic_done never pulses, err=0, mem_rd=0.
